// File: rtl/combo6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : combo6_pkg
// Description : Shared types, widths and helpers for the 6-bit fixed-popcount
//               word generator.
// Revision    : 1.0 - initial release
// ============================================================================
package combo6_pkg;

  localparam int WORD_W  = 6;
  localparam int INDEX_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Smallest word with k ones: (1<<k)-1, evaluated one bit wider so k=6 fits.
  function automatic logic [WORD_W-1:0] first_word(input logic [2:0] k);
    logic [WORD_W:0] t;
    t = (7'd1 << k) - 7'd1;
    return t[WORD_W-1:0];
  endfunction

  // Number of set bits in a word.
  function automatic logic [2:0] popcnt6(input logic [WORD_W-1:0] w);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) begin
      n = n + {2'b00, w[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/combo6_next.sv
`default_nettype none
// ============================================================================
// Module      : combo6_next
// Description : Next word with the same popcount (Gosper step), purely
//               combinational, plus a flag marking the highest such word.
// Revision    : 1.0 - initial release
// ============================================================================
module combo6_next
  import combo6_pkg::*;
#(
  parameter bit ABSTRACT_MODEL = 1'b0
) (
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] next_o,
  output logic              last_o
);

  if (ABSTRACT_MODEL) begin : g_abstract
    logic [WORD_W-1:0] r_unused_cand;

    // Behavioural search: first larger word with equal popcount.
    always_comb begin
      next_o        = word_i;
      last_o        = 1'b1;
      r_unused_cand = '0;
      for (int v = 0; v < (1 << WORD_W); v++) begin
        r_unused_cand = WORD_W'(v);
        if (last_o && (r_unused_cand > word_i) &&
            (popcnt6(r_unused_cand) == popcnt6(word_i))) begin
          next_o = r_unused_cand;
          last_o = 1'b0;
        end
      end
    end
  end else begin : g_gosper
    logic [WORD_W:0]   w_x;
    logic [WORD_W:0]   w_low;
    logic [WORD_W:0]   w_ripple;
    logic [WORD_W:0]   w_ones;
    logic [WORD_W-1:0] w_tail;

    // Lowest set bit, then ripple it into the next zero above the low run.
    assign w_x      = {1'b0, word_i};
    assign w_low    = w_x & (~w_x + 7'd1);
    assign w_ripple = w_x + w_low;
    assign w_ones   = (w_ripple ^ w_x) >> 2;

    // Divide by the one-hot lowest bit: a right shift by its position.
    always_comb begin
      case (w_low[WORD_W-1:0])
        6'b000001: w_tail = w_ones[WORD_W-1:0];
        6'b000010: w_tail = w_ones[WORD_W-1:0] >> 1;
        6'b000100: w_tail = w_ones[WORD_W-1:0] >> 2;
        6'b001000: w_tail = w_ones[WORD_W-1:0] >> 3;
        6'b010000: w_tail = w_ones[WORD_W-1:0] >> 4;
        6'b100000: w_tail = w_ones[WORD_W-1:0] >> 5;
        default:   w_tail = '0;
      endcase
    end

    // Carry out of the top bit means the ones are already packed high.
    assign next_o = w_ripple[WORD_W-1:0] | w_tail;
    assign last_o = w_ripple[WORD_W] | (word_i == '0);
  end

endmodule
`default_nettype wire

// File: rtl/combo6_gen.sv
`default_nettype none
// ============================================================================
// Module      : combo6_gen
// Description : Streams every 6-bit word with a requested popcount k in
//               ascending order over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module combo6_gen
  import combo6_pkg::*;
#(
  parameter bit ABSTRACT_MODEL = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [2:0]         i_count,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WORD_W-1:0]  o_word,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic [INDEX_W-1:0] o_index,
  output logic               o_error,
  input  logic               i_abort
);

  state_e              state_q;
  logic [WORD_W-1:0]   word_q;
  logic [INDEX_W-1:0]  index_q;
  logic                valid_q;
  logic                error_q;

  logic [WORD_W-1:0]   w_next_word;
  logic                w_is_last;
  logic                w_handshake;

  combo6_next #(
    .ABSTRACT_MODEL(ABSTRACT_MODEL)
  ) u_next (
    .word_i (word_q),
    .next_o (w_next_word),
    .last_o (w_is_last)
  );

  assign w_handshake = valid_q & i_ready;

  // Control FSM: accept a request, step through the words, return to IDLE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (i_count == 3'd7) begin
              error_q <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              word_q  <= first_word(i_count);
              index_q <= '0;
            end
          end
        end
        RUN: begin
          if (w_handshake) begin
            if (w_is_last) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              word_q  <= '0;
              index_q <= '0;
            end else begin
              word_q  <= w_next_word;
              index_q <= index_q + 5'd1;
            end
          end
          // Abort wins over any step taken above; a same-cycle handshake
          // has still been consumed by the downstream side.
          if (i_abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            word_q  <= '0;
            index_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = valid_q;
  assign o_word  = word_q;
  assign o_index = index_q;
  assign o_last  = valid_q & w_is_last;
  assign o_error = error_q;

endmodule
`default_nettype wire

// File: doc/combo6_gen.md
COMBO6_GEN -- requirements
Module: combo6_gen

Interface
REQ-001 SHALL have parameter ABSTRACT_MODEL, default 0; when set, the next-word logic may use a behavioural loop instead of gate-level logic.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_count, input, 3 bits: requested population count k.
REQ-005 SHALL have port i_valid, input, 1 bit: i_count is valid.
REQ-006 SHALL have port o_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have port o_word, output, 6 bits: generated word with popcount k.
REQ-008 SHALL have port o_valid, output, 1 bit: o_word is valid.
REQ-009 SHALL have port i_ready, input, 1 bit: consumer accepts o_word.
REQ-010 SHALL have port o_last, output, 1 bit: o_word is the final word of the sequence.
REQ-011 SHALL have port o_index, output, 5 bits: zero-based position of o_word in the sequence.
REQ-012 SHALL have port o_error, output, 1 bit: one-cycle pulse on an illegal request.
REQ-013 SHALL have port i_abort, input, 1 bit: synchronous termination of the active sequence.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; o_ready = (state == IDLE).
REQ-015 SHALL accept a request when i_valid && o_ready in IDLE.
REQ-016 On accepting k in 0..6, SHALL enter RUN and assert o_valid on the next cycle with o_word = (1<<k)-1 and o_index = 0.
REQ-017 SHALL emit every 6-bit word with popcount k exactly once, in strictly ascending numeric order: C(6,k) words, i.e. 1,6,15,20,15,6,1.
REQ-018 SHALL advance to the next word, with o_index+1, on each cycle where o_valid && i_ready, giving one word per cycle with no bubbles.
REQ-019 SHALL hold o_word, o_index and o_last stable while o_valid && !i_ready.
REQ-020 SHALL assert o_last only with the highest word, ((1<<k)-1)<<(6-k); for k=0 and k=6 the single word carries o_last.
REQ-021 On handshake of the o_last word, SHALL return to IDLE, with o_valid=0 and o_ready=1 on the next cycle; the earliest next request is accepted that cycle.
REQ-022 On accepting k=7, SHALL stay in IDLE, never assert o_valid, and pulse o_error for exactly the next cycle.
REQ-023 i_abort in RUN SHALL force IDLE on the next cycle with o_valid=0; a handshake in the same cycle completes first; i_abort in IDLE SHALL have no effect.
REQ-024 The next-word computation SHALL be combinational from the current word (Gosper step), with no multi-cycle arithmetic.
REQ-025 i_count and i_valid SHALL be ignored outside IDLE.

Reset
REQ-026 i_rstn low SHALL immediately force: state IDLE, o_ready=1, o_valid=0, o_word=0, o_last=0, o_index=0, o_error=0.
REQ-027 Reset asserted mid-sequence SHALL discard the sequence; after deassertion no residual word is emitted.

Structure
REQ-028 Package combo6_pkg SHALL hold the state enum (IDLE, RUN), the word width constant (6), and the index width constant (5).
REQ-029 The next-word logic SHALL live in one sub-module, combo6_next: input word, output next word and is-last flag, with an ABSTRACT_MODEL parameter.

Verification
REQ-030 k=2, i_ready=1 -> 15 consecutive words 000011, 000101, 000110, 001001, ..., 110000; o_last and o_index=14 on the final word.
REQ-031 k=0 -> single word 000000 with o_last=1 and o_index=0; k=6 -> single word 111111 with o_last=1.
REQ-032 k=7 -> o_error high exactly one cycle, o_valid never asserted, o_ready remains 1.
REQ-033 k=3, i_ready low for 3 cycles while o_word=001101 -> o_word and o_index=2 held stable, then sequence resumes with 001110.
REQ-034 k=3, i_abort after 5 handshakes -> o_valid=0 next cycle, o_ready=1, and a new k=1 request yields 000001.
REQ-035 All runs: every emitted word checked against popcnt6 output == k; no duplicates; count equals C(6,k).
